// File: rtl/rs_bank_pkg.sv
// Shared tag/CDB widths, per-entry state encoding and CDB match helper for the
// reservation-station bank.
package rs_bank_pkg;

  localparam int NUM_SRBITS  = 4;
  localparam int DATA_W      = 32;
  localparam int NUM_CDBBITS = 1 + NUM_SRBITS + DATA_W;

  typedef logic [NUM_SRBITS-1:0] tag_t;
  typedef logic [DATA_W-1:0]     data_t;

  typedef enum logic [1:0] {
    RS_ST_FREE  = 2'd0,
    RS_ST_WAIT  = 2'd1,
    RS_ST_READY = 2'd2,
    RS_ST_EXEC  = 2'd3
  } rs_state_e;

  function automatic tag_t entry_tag(input int base, input int idx);
    return tag_t'(base + idx);
  endfunction

  // Tag 0 means "value already valid", so it never matches a broadcast.
  function automatic logic cdb_hit(input logic on, input tag_t bus_tag, input tag_t t);
    return on && (t != '0) && (t == bus_tag);
  endfunction

endpackage

// File: rtl/rs_bank_if.sv
// Dispatch, CDB and issue signals of the reservation-station bank.
interface rs_bank_if #(parameter int OP_W = 4);
  import rs_bank_pkg::*;

  logic                   flush;
  logic                   disp_valid;
  logic                   disp_ready;
  logic [OP_W-1:0]        disp_op;
  logic [NUM_CDBBITS-2:0] disp_srcA;
  logic [NUM_CDBBITS-2:0] disp_srcB;
  tag_t                   disp_tag;
  logic [NUM_CDBBITS-1:0] cdb;
  logic                   iss_valid;
  logic                   iss_ready;
  logic [OP_W-1:0]        iss_op;
  data_t                  iss_a;
  data_t                  iss_b;
  tag_t                   iss_tag;

  modport master (
    output flush, disp_valid, disp_op, disp_srcA, disp_srcB, cdb, iss_ready,
    input  disp_ready, disp_tag, iss_valid, iss_op, iss_a, iss_b, iss_tag
  );

  modport slave (
    input  flush, disp_valid, disp_op, disp_srcA, disp_srcB, cdb, iss_ready,
    output disp_ready, disp_tag, iss_valid, iss_op, iss_a, iss_b, iss_tag
  );

endinterface

// File: rtl/rs_select.sv
// DEPTH-wide picker returning the lowest-index requester, or the one with the
// smallest age when RS_AGE_PRIORITY_EN is defined.
module rs_select #(
  parameter int DEPTH = 4
`ifdef RS_AGE_PRIORITY_EN
  , parameter int AGE_W = 3
`endif
) (
  input  logic [DEPTH-1:0]            req,
`ifdef RS_AGE_PRIORITY_EN
  input  logic [DEPTH-1:0][AGE_W-1:0] age,
`endif
  output logic [$clog2(DEPTH)-1:0]    idx,
  output logic                        any
);

  localparam int IDX_W = $clog2(DEPTH);

`ifdef RS_AGE_PRIORITY_EN
  logic [AGE_W-1:0] best;
`endif

  // Strict compare keeps the lowest index on equal ages.
  always_comb begin
    idx = '0;
    any = 1'b0;
`ifdef RS_AGE_PRIORITY_EN
    best = '1;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (req[i]) begin
`ifdef RS_AGE_PRIORITY_EN
        if (!any || (age[i] < best)) begin
          any  = 1'b1;
          idx  = IDX_W'(i);
          best = age[i];
        end
`else
        if (!any) begin
          any = 1'b1;
          idx = IDX_W'(i);
        end
`endif
      end
    end
  end

endmodule

// File: rtl/rs_bank.sv
// Tomasulo reservation-station bank: allocates entries, snoops the CDB and issues
// ready ops to one FU. Optional oldest-first issue under RS_AGE_PRIORITY_EN.
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TAG_BASE = 1,
  parameter int OP_W     = 4
) (
  input logic      clk,
  input logic      rst_n,
  rs_bank_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  rs_state_e       state    [DEPTH];
  rs_state_e       state_nx [DEPTH];
  logic [OP_W-1:0] op       [DEPTH];
  logic [OP_W-1:0] op_nx    [DEPTH];
  tag_t            a_tag    [DEPTH];
  tag_t            a_tag_nx [DEPTH];
  tag_t            b_tag    [DEPTH];
  tag_t            b_tag_nx [DEPTH];
  data_t           a_val    [DEPTH];
  data_t           a_val_nx [DEPTH];
  data_t           b_val    [DEPTH];
  data_t           b_val_nx [DEPTH];

  logic [DEPTH-1:0] free_vec, ready_vec;
  logic [IDX_W-1:0] alloc_idx, iss_idx;
  logic             any_free, any_ready;
  logic             disp_fire, iss_fire;
  logic             cdb_on;
  tag_t             cdb_tag, da_tag, db_tag;
  data_t            cdb_data, da_val, db_val;

`ifdef RS_AGE_PRIORITY_EN
  localparam int AGE_W = IDX_W + 1;
  logic [DEPTH-1:0][AGE_W-1:0] age, age_nx;
  logic [AGE_W-1:0]            pend_cnt, iss_age;
`endif

  assign {cdb_on, cdb_tag, cdb_data} = bus.cdb;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i]  = (state[i] == RS_ST_FREE);
      ready_vec[i] = (state[i] == RS_ST_READY);
    end
  end

  // Allocation always takes the lowest free slot; all-zero ages give that order.
  rs_select #(
    .DEPTH(DEPTH)
`ifdef RS_AGE_PRIORITY_EN
    , .AGE_W(AGE_W)
`endif
  ) u_alloc (
    .req(free_vec),
`ifdef RS_AGE_PRIORITY_EN
    .age('0),
`endif
    .idx(alloc_idx),
    .any(any_free)
  );

  rs_select #(
    .DEPTH(DEPTH)
`ifdef RS_AGE_PRIORITY_EN
    , .AGE_W(AGE_W)
`endif
  ) u_issue (
    .req(ready_vec),
`ifdef RS_AGE_PRIORITY_EN
    .age(age),
`endif
    .idx(iss_idx),
    .any(any_ready)
  );

  assign disp_fire      = bus.disp_valid & any_free & ~bus.flush;
  assign iss_fire       = any_ready & bus.iss_ready & ~bus.flush;
  assign bus.disp_ready = any_free;
  assign bus.disp_tag   = entry_tag(TAG_BASE, int'(alloc_idx));
  assign bus.iss_valid  = any_ready;
  assign bus.iss_op     = any_ready ? op[iss_idx]    : '0;
  assign bus.iss_a      = any_ready ? a_val[iss_idx] : '0;
  assign bus.iss_b      = any_ready ? b_val[iss_idx] : '0;
  assign bus.iss_tag    = any_ready ? entry_tag(TAG_BASE, int'(iss_idx)) : '0;

  // Operands arriving on the CDB in the dispatch cycle are captured directly.
  always_comb begin
    {da_tag, da_val} = bus.disp_srcA;
    {db_tag, db_val} = bus.disp_srcB;
    if (cdb_hit(cdb_on, cdb_tag, da_tag)) begin
      da_tag = '0;
      da_val = cdb_data;
    end
    if (cdb_hit(cdb_on, cdb_tag, db_tag)) begin
      db_tag = '0;
      db_val = cdb_data;
    end
  end

`ifdef RS_AGE_PRIORITY_EN
  // Age is the rank among not-yet-issued entries; 0 is the oldest.
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((state[i] == RS_ST_WAIT) || (state[i] == RS_ST_READY)) begin
        pend_cnt = pend_cnt + AGE_W'(1);
      end
    end
    iss_age = age[iss_idx];
  end
`endif

  always_comb begin
    state_nx = state;
    op_nx    = op;
    a_tag_nx = a_tag;
    a_val_nx = a_val;
    b_tag_nx = b_tag;
    b_val_nx = b_val;
`ifdef RS_AGE_PRIORITY_EN
    age_nx   = age;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.flush) begin
        state_nx[i] = RS_ST_FREE;
        op_nx[i]    = '0;
        a_tag_nx[i] = '0;
        a_val_nx[i] = '0;
        b_tag_nx[i] = '0;
        b_val_nx[i] = '0;
`ifdef RS_AGE_PRIORITY_EN
        age_nx[i]   = '0;
`endif
      end else begin
        case (state[i])
          RS_ST_FREE: begin
            if (disp_fire && (alloc_idx == IDX_W'(i))) begin
              op_nx[i]    = bus.disp_op;
              a_tag_nx[i] = da_tag;
              a_val_nx[i] = da_val;
              b_tag_nx[i] = db_tag;
              b_val_nx[i] = db_val;
              state_nx[i] = ((da_tag == '0) && (db_tag == '0)) ? RS_ST_READY : RS_ST_WAIT;
`ifdef RS_AGE_PRIORITY_EN
              age_nx[i]   = pend_cnt - AGE_W'(iss_fire);
`endif
            end
          end
          RS_ST_WAIT: begin
            if (cdb_hit(cdb_on, cdb_tag, a_tag[i])) begin
              a_tag_nx[i] = '0;
              a_val_nx[i] = cdb_data;
            end
            if (cdb_hit(cdb_on, cdb_tag, b_tag[i])) begin
              b_tag_nx[i] = '0;
              b_val_nx[i] = cdb_data;
            end
            if ((a_tag_nx[i] == '0) && (b_tag_nx[i] == '0)) begin
              state_nx[i] = RS_ST_READY;
            end
          end
          RS_ST_READY: begin
            if (iss_fire && (iss_idx == IDX_W'(i))) begin
              state_nx[i] = RS_ST_EXEC;
            end
          end
          RS_ST_EXEC: begin
            if (cdb_on && (cdb_tag == entry_tag(TAG_BASE, i))) begin
              state_nx[i] = RS_ST_FREE;
            end
          end
          default: state_nx[i] = RS_ST_FREE;
        endcase
`ifdef RS_AGE_PRIORITY_EN
        if (((state[i] == RS_ST_WAIT) || (state[i] == RS_ST_READY)) && iss_fire && (age[i] > iss_age)) begin
          age_nx[i] = age[i] - AGE_W'(1);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        state[i] <= RS_ST_FREE;
        op[i]    <= '0;
        a_tag[i] <= '0;
        a_val[i] <= '0;
        b_tag[i] <= '0;
        b_val[i] <= '0;
      end
`ifdef RS_AGE_PRIORITY_EN
      age <= '0;
`endif
    end else begin
      state <= state_nx;
      op    <= op_nx;
      a_tag <= a_tag_nx;
      a_val <= a_val_nx;
      b_tag <= b_tag_nx;
      b_val <= b_val_nx;
`ifdef RS_AGE_PRIORITY_EN
      age   <= age_nx;
`endif
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// Self-checking bench for rs_bank: directed scenarios plus random traffic against
// an entry-level reference model, with issued ops checked through a scoreboard.
module tb_rs_bank;
  import rs_bank_pkg::*;

  localparam int DEPTH    = 4;
  localparam int TAG_BASE = 1;
  localparam int OP_W     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_bank_if #(.OP_W(OP_W)) bus();

  rs_bank #(.DEPTH(DEPTH), .TAG_BASE(TAG_BASE), .OP_W(OP_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [OP_W-1:0] op;
    data_t           a;
    data_t           b;
    tag_t            tag;
  } iss_t;

  iss_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one record per entry, operand values known or awaited by tag.
  bit              m_busy   [DEPTH];
  bit              m_issued [DEPTH];
  bit              m_ka     [DEPTH];
  bit              m_kb     [DEPTH];
  tag_t            m_ta     [DEPTH];
  tag_t            m_tb     [DEPTH];
  data_t           m_a      [DEPTH];
  data_t           m_b      [DEPTH];
  logic [OP_W-1:0] m_op     [DEPTH];
  int              m_seq    [DEPTH];
  int              seq_ctr = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelClear();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i]   = 1'b0;
      m_issued[i] = 1'b0;
      m_ka[i]     = 1'b0;
      m_kb[i]     = 1'b0;
    end
  endfunction

  function automatic void setIdle();
    bus.flush      = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_op    = '0;
    bus.disp_srcA  = '0;
    bus.disp_srcB  = '0;
    bus.cdb        = '0;
    bus.iss_ready  = 1'b0;
  endfunction

  task automatic applyStimulus(input bit fl, input bit dv, input logic [OP_W-1:0] op,
                               input logic [35:0] sa, input logic [35:0] sb,
                               input logic [36:0] cdb, input bit ir);
    int    fi;
    int    sel;
    bit    on;
    tag_t  ct;
    data_t cd;
    @(negedge clk);
    bus.flush      = fl;
    bus.disp_valid = dv;
    bus.disp_op    = op;
    bus.disp_srcA  = sa;
    bus.disp_srcB  = sb;
    bus.cdb        = cdb;
    bus.iss_ready  = ir;
    #1;
    fi = -1;
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i] && fi < 0) fi = i;
    checkOutput("disp_ready", 32'(bus.disp_ready), 32'(fi >= 0));
    if (fi >= 0) checkOutput("disp_tag", 32'(bus.disp_tag), 32'(TAG_BASE + fi));
    sel = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && !m_issued[i] && m_ka[i] && m_kb[i]) begin
`ifdef RS_AGE_PRIORITY_EN
        if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    checkOutput("iss_valid", 32'(bus.iss_valid), 32'(sel >= 0));
    if (fl) begin
      modelClear();
      return;
    end
    {on, ct, cd} = cdb;
    if (sel >= 0 && ir) exp_q.push_back({m_op[sel], m_a[sel], m_b[sel], tag_t'(TAG_BASE + sel)});
    if (on && ct != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_busy[i] && !m_issued[i]) begin
          if (!m_ka[i] && m_ta[i] == ct) begin m_ka[i] = 1'b1; m_a[i] = cd; end
          if (!m_kb[i] && m_tb[i] == ct) begin m_kb[i] = 1'b1; m_b[i] = cd; end
        end
        if (m_busy[i] && m_issued[i] && ct == tag_t'(TAG_BASE + i)) m_busy[i] = 1'b0;
      end
    end
    if (sel >= 0 && ir) m_issued[sel] = 1'b1;
    if (dv && fi >= 0) begin
      m_busy[fi]   = 1'b1;
      m_issued[fi] = 1'b0;
      m_op[fi]     = op;
      m_seq[fi]    = seq_ctr++;
      m_ta[fi]     = sa[35:32];
      m_tb[fi]     = sb[35:32];
      m_a[fi]      = sa[31:0];
      m_b[fi]      = sb[31:0];
      m_ka[fi]     = (sa[35:32] == '0) || (on && ct == sa[35:32]);
      m_kb[fi]     = (sb[35:32] == '0) || (on && ct == sb[35:32]);
      if (sa[35:32] != '0 && on && ct == sa[35:32]) m_a[fi] = cd;
      if (sb[35:32] != '0 && on && ct == sb[35:32]) m_b[fi] = cd;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    setIdle();
    #1;
    modelClear();
    exp_q.delete();
    checkOutput("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
    checkOutput("rst_disp_tag", 32'(bus.disp_tag), 32'(TAG_BASE));
    checkOutput("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    checkOutput("rst_iss_op", 32'(bus.iss_op), 32'd0);
    checkOutput("rst_iss_a", bus.iss_a, 32'd0);
    checkOutput("rst_iss_b", bus.iss_b, 32'd0);
    checkOutput("rst_iss_tag", 32'(bus.iss_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic tag_t randTag();
    int r = $urandom_range(0, 9);
    if (r < 5) return '0;
    if (r < 8) return tag_t'(9 + $urandom_range(0, 3));
    return tag_t'(TAG_BASE + $urandom_range(0, DEPTH - 1));
  endfunction

  // Monitor: pops one expected op for every accepted issue handshake.
  initial begin
    iss_t got;
    iss_t exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.iss_valid && bus.iss_ready && !bus.flush) begin
        checks++;
        got = {bus.iss_op, bus.iss_a, bus.iss_b, bus.iss_tag};
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL iss_unexpected: got op=%0h a=%0h b=%0h tag=%0h, none expected",
                   got.op, got.a, got.b, got.tag);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("[TB] FAIL iss_pkt: got op=%0h a=%0h b=%0h tag=%0h expected op=%0h a=%0h b=%0h tag=%0h",
                     got.op, got.a, got.b, got.tag, exp.op, exp.a, exp.b, exp.tag);
          end
        end
      end
    end
  end

  initial begin
    bit          fl, dv, ir;
    logic [36:0] cdb;
    int          cand[$];
    setIdle();
    modelClear();
    doReset();

    // Both operands valid at dispatch.
    applyStimulus(0, 1, 4'h3, {4'd0, 32'd5}, {4'd0, 32'd7}, '0, 0);
    applyStimulus(0, 0, '0, '0, '0, '0, 1);
    checkOutput("t1_iss_a", bus.iss_a, 32'd5);
    checkOutput("t1_iss_b", bus.iss_b, 32'd7);
    checkOutput("t1_iss_tag", 32'(bus.iss_tag), 32'(TAG_BASE));
    applyStimulus(0, 0, '0, '0, '0, {1'b1, 4'd1, 32'd0}, 0);

    // Foreign tag woken by the CDB.
    applyStimulus(0, 1, 4'h5, {4'd9, 32'h1111}, {4'd0, 32'd2}, '0, 0);
    applyStimulus(0, 0, '0, '0, '0, '0, 1);
    applyStimulus(0, 0, '0, '0, '0, {1'b1, 4'd9, 32'hAB}, 1);
    applyStimulus(0, 0, '0, '0, '0, '0, 1);
    checkOutput("t2_iss_a", bus.iss_a, 32'hAB);
    applyStimulus(0, 0, '0, '0, '0, {1'b1, 4'd1, 32'd0}, 0);

    // Same-cycle CDB bypass at dispatch.
    applyStimulus(0, 1, 4'h6, {4'd0, 32'd1}, {4'd9, 32'h55}, {1'b1, 4'd9, 32'd3}, 0);
    applyStimulus(0, 0, '0, '0, '0, '0, 1);
    checkOutput("t3_iss_b", bus.iss_b, 32'd3);
    applyStimulus(0, 0, '0, '0, '0, {1'b1, 4'd1, 32'd0}, 0);

    // Fill, issue three, free TAG_BASE+2.
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, OP_W'(i + 8), {4'd0, 32'(i)}, {4'd0, 32'(i * 3)}, '0, 0);
    applyStimulus(0, 1, 4'hF, '0, '0, '0, 1);
    checkOutput("t4_full", 32'(bus.disp_ready), 32'd0);
    applyStimulus(0, 0, '0, '0, '0, '0, 1);
    applyStimulus(0, 0, '0, '0, '0, '0, 1);
    applyStimulus(0, 0, '0, '0, '0, {1'b1, 4'(TAG_BASE + 2), 32'd0}, 0);
    applyStimulus(0, 0, '0, '0, '0, '0, 0);
    checkOutput("t4_ready", 32'(bus.disp_ready), 32'd1);
    checkOutput("t4_tag", 32'(bus.disp_tag), 32'(TAG_BASE + 2));

    // Flush with three busy entries and a same-cycle dispatch.
    applyStimulus(1, 1, 4'h1, '0, '0, {1'b1, 4'd1, 32'd0}, 1);
    applyStimulus(0, 0, '0, '0, '0, '0, 0);
    checkOutput("t5_iss_valid", 32'(bus.iss_valid), 32'd0);
    checkOutput("t5_disp_tag", 32'(bus.disp_tag), 32'(TAG_BASE));

    // Reset pulse mid-stream.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'h2, {4'd0, 32'd4}, {4'd10, 32'd0}, '0, 0);
    doReset();
    applyStimulus(0, 0, '0, '0, '0, '0, 1);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) doReset();
      cand.delete();
      for (int i = 0; i < DEPTH; i++) if (m_busy[i] && m_issued[i]) cand.push_back(i);
      fl = ($urandom_range(0, 59) == 0);
      dv = ($urandom_range(0, 2) != 0);
      ir = ($urandom_range(0, 3) != 0);
      cdb = {1'b0, 4'd0, 32'($urandom)};
      if ($urandom_range(0, 2) != 0) begin
        if (cand.size() > 0 && $urandom_range(0, 1) == 1)
          cdb[36:32] = {1'b1, 4'(TAG_BASE + cand[$urandom_range(0, cand.size() - 1)])};
        else
          cdb[36:32] = {1'b1, 4'($urandom_range(0, 12))};
      end
      applyStimulus(fl, dv, OP_W'($urandom), {randTag(), 32'($urandom)},
                    {randTag(), 32'($urandom)}, cdb, ir);
    end

    applyStimulus(0, 0, '0, '0, '0, '0, 0);
    applyStimulus(0, 0, '0, '0, '0, '0, 0);
    checkOutput("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
